mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 64: width of all address ports.
REQ-002 Ports, one per line (name  direction  width  meaning); clock is clk, reset is rst; one clock; rst is asynchronous and active-high.
- clk  input  1  sole clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- i_ren  input  1  instruction read request, held until i_rvalid.
- i_raddr  input  ADDR_WIDTH  instruction read address, 16-byte line.
- i_rdata  output  128  instruction read data.
- i_rvalid  output  1  one-cycle instruction read completion pulse.
- d_ren  input  1  data read request, held until d_rvalid.
- d_raddr  input  ADDR_WIDTH  data read address.
- d_wen  input  1  data write request, held until d_wvalid.
- d_waddr  input  ADDR_WIDTH  data write address.
- d_wdata  input  128  data write line.
- d_wmask  input  16  byte write mask.
- d_rdata  output  128  data read data.
- d_rvalid  output  1  one-cycle data read completion pulse.
- d_wvalid  output  1  one-cycle data write completion pulse.
- m_ren, m_raddr, m_wen, m_waddr, m_wdata, m_wmask  output  1/ADDR_WIDTH/1/ADDR_WIDTH/128/16  master side to downstream line RAM.
- m_rdata, m_rvalid, m_wvalid  input  128/1/1  downstream RAM responses.

Function
REQ-003 FSM states: IDLE, I_RD, D_RD, D_WR, DONE; state register only, grant decided in IDLE.
REQ-004 IDLE: no m_ren/m_wen; on pending requests move to the granted state on the next edge.
REQ-005 Within the data port, d_wen wins over d_ren when both asserted (write-first).
REQ-006 Default arbitration: any data request beats i_ren.
REQ-007 I_RD/D_RD: m_ren=1, m_raddr from granted port; m_wen=0.
REQ-008 D_WR: m_wen=1, m_waddr/m_wdata/m_wmask from data port; m_ren=0.
REQ-009 m_rdata routed combinationally to both i_rdata and d_rdata; only the granted port's rvalid pulses.
REQ-010 In I_RD/D_RD, first cycle m_rvalid=1: pulse granted rvalid for exactly that cycle, next state DONE.
REQ-011 In D_WR, first cycle m_wvalid=1: pulse d_wvalid for that cycle, next state DONE.
REQ-012 DONE: all m_ren/m_wen and completion outputs 0 for exactly one cycle (lets RAM FSMs return idle), then IDLE.
REQ-013 Requester must deassert its request in the DONE cycle; a request still high in IDLE is a new transaction.
REQ-014 Granted master's address/data must stay stable while in a non-IDLE state; arbiter does not latch them.
REQ-015 With downstream line RAM: read completes 3 cycles after request seen in IDLE, write 2 cycles; back-to-back transaction spacing = latency + 2 cycles.
REQ-016 Requests dropped mid-transaction are undefined; arbiter stays in state until response.
REQ-017 m_rvalid/m_wvalid in IDLE or DONE ignored.

Reset
REQ-018 rst asserted: state=IDLE and all outputs (m_ren, m_wen, i_rvalid, d_rvalid, d_wvalid) 0 immediately, asynchronously.
REQ-019 rst mid-transaction abandons it; no completion pulse issued; round-robin pointer (if present) resets to favour data.
REQ-020 First grant possible in the first cycle after rst deasserts.

Configuration
REQ-021 Macro ARB_ROUND_ROBIN_EN defined: 1-bit last-grant pointer; on contention, port not granted last wins; pointer updates on each grant.
REQ-022 ARB_ROUND_ROBIN_EN undefined: fixed data-over-instruction priority per REQ-006, no pointer register.

Verification
REQ-023 i_ren=1, raddr=0x40 alone -> m_ren cycles 1-3, i_rvalid one pulse cycle 3 with line 0x40 data, DONE cycle 4.
REQ-024 d_wen=1, waddr=0x80, wmask=0xFFFF, wdata=0xA5.. -> d_wvalid cycle 2; subsequent d_ren 0x80 returns written line.
REQ-025 i_ren and d_ren same cycle, macro off -> data served first, instruction served after DONE; repeat 4x, instruction starved while data held.
REQ-026 Same contention, ARB_ROUND_ROBIN_EN on, continuous requests -> grants alternate D,I,D,I.
REQ-027 d_wen and d_ren together -> write completes before read; read returns new data.
REQ-028 rst pulse during D_RD cycle 2 -> outputs 0 immediately, no d_rvalid, new i_ren served normally afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-ported line RAM.
//
// Purpose
//   Shares one downstream line RAM between an instruction read port and a
//   data read/write port. One transaction is in flight at a time:
//   IDLE -> {I_RD | D_RD | D_WR} -> DONE -> IDLE.
//   The grant is decided in IDLE only. Within the data port, a write beats a
//   read. Between ports, data beats instruction by default.
//
// Configuration
//   ARB_ROUND_ROBIN_EN (macro): when defined, a 1-bit last-grant pointer
//   replaces the fixed priority. On contention, the port that was not granted
//   last wins. Reset leaves the pointer favouring the data port.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   i_ren/i_raddr               instruction read request (held until i_rvalid)
//   i_rdata/i_rvalid            instruction read data / one-cycle completion
//   d_ren/d_raddr               data read request (held until d_rvalid)
//   d_wen/d_waddr/d_wdata/d_wmask  data write request (held until d_wvalid)
//   d_rdata/d_rvalid/d_wvalid   data read data / read and write completions
//   m_ren/m_raddr/m_wen/m_waddr/m_wdata/m_wmask  requests to the line RAM
//   m_rdata/m_rvalid/m_wvalid   line RAM responses
//
// Request addresses and write data are not latched. The granted requester
// must hold them stable until its completion pulse.

module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_ren,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [127:0]          i_rdata,
  output logic                  i_rvalid,

  input  logic                  d_ren,
  input  logic [ADDR_WIDTH-1:0] d_raddr,
  input  logic                  d_wen,
  input  logic [ADDR_WIDTH-1:0] d_waddr,
  input  logic [127:0]          d_wdata,
  input  logic [15:0]           d_wmask,
  output logic [127:0]          d_rdata,
  output logic                  d_rvalid,
  output logic                  d_wvalid,

  output logic                  m_ren,
  output logic [ADDR_WIDTH-1:0] m_raddr,
  output logic                  m_wen,
  output logic [ADDR_WIDTH-1:0] m_waddr,
  output logic [127:0]          m_wdata,
  output logic [15:0]           m_wmask,
  input  logic [127:0]          m_rdata,
  input  logic                  m_rvalid,
  input  logic                  m_wvalid
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_next;
  logic   data_grant;

  // Read data is shared. Only the granted port's valid pulse qualifies it.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  // The pointer is set when the data port was granted last. Its reset value
  // of 0 lets the data port win the first contention.
  logic last_data;

  assign data_grant = (d_wen | d_ren) & ~(i_ren & last_data);

  // Last-grant pointer, updated on every grant taken from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data <= 1'b0;
    end else if ((state == IDLE) && (state_next != IDLE)) begin
      last_data <= (state_next != I_RD);
    end
  end
`else
  // Fixed priority: any data request beats the instruction port.
  assign data_grant = d_wen | d_ren;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Stays in the transfer state until the RAM responds.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (data_grant) begin
          state_next = d_wen ? D_WR : D_RD;
        end else if (i_ren) begin
          state_next = I_RD;
        end
      end
      I_RD, D_RD: begin
        if (m_rvalid) begin
          state_next = DONE;
        end
      end
      D_WR: begin
        if (m_wvalid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode. Completion pulses follow the RAM response for the single
  // cycle before the move to DONE. RAM responses seen in IDLE or DONE are
  // dropped here.
  always_comb begin
    m_ren    = 1'b0;
    m_raddr  = '0;
    m_wen    = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_wmask  = '0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    d_wvalid = 1'b0;
    case (state)
      I_RD: begin
        m_ren    = 1'b1;
        m_raddr  = i_raddr;
        i_rvalid = m_rvalid;
      end
      D_RD: begin
        m_ren    = 1'b1;
        m_raddr  = d_raddr;
        d_rvalid = m_rvalid;
      end
      D_WR: begin
        m_wen    = 1'b1;
        m_waddr  = d_waddr;
        m_wdata  = d_wdata;
        m_wmask  = d_wmask;
        d_wvalid = m_wvalid;
      end
      default: begin
      end
    endcase
  end

endmodule
